// File: rtl/dp_fifos_reset_pkg.sv
// Shared state codes and helpers for the dual-clock FIFO reset sequencer.
package dp_fifos_reset_pkg;

   localparam int unsigned ST_RST_HOLD      = 0;
   localparam int unsigned ST_WAIT_BUSY_OFF = 1;
   localparam int unsigned ST_DONE          = 2;
   localparam int unsigned ST_ERROR         = 3;

   typedef enum int unsigned {
      SEQ_RST_HOLD      = ST_RST_HOLD,
      SEQ_WAIT_BUSY_OFF = ST_WAIT_BUSY_OFF,
      SEQ_DONE          = ST_DONE,
      SEQ_ERROR         = ST_ERROR
   } seq_state_e;

   function automatic int unsigned cnt_width(
      input int unsigned a,
      input int unsigned b
   );
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

   function automatic logic is_legal_state(input int unsigned s);
      return s <= ST_ERROR;
   endfunction

endpackage

// File: rtl/dp_fifos_reset_seq_busy_reduce.sv
// Registers per-FIFO rd|wr reset-busy and reduces it to a single any-busy flag.
module dp_fifos_busy_reduce #(
   parameter int NumFifos = 4
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic [NumFifos-1:0] wr_busy_i,
   input  logic [NumFifos-1:0] rd_busy_i,
   output logic [NumFifos-1:0] busy_status_o,
   output logic                any_busy_o
);

   logic [NumFifos-1:0] r_busy;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) r_busy <= '0;
      else        r_busy <= wr_busy_i | rd_busy_i;
   end

   assign busy_status_o = r_busy;
   assign any_busy_o    = |r_busy;

endmodule

// File: rtl/dp_fifos_reset_seq.sv
// Reset sequencer for a group of dual-clock FIFOs with TMR state export.
// Optional macro DP_FIFOS_RST_SEQ_COUNT_EN adds rst_count_o (entries into DONE).
module dp_fifos_reset_seq
   import dp_fifos_reset_pkg::*;
#(
   parameter int NumFifos      = 4,
   parameter int RstHoldCycles = 3,
   parameter int BusyTimeout   = 256,
   parameter int StateBitWidth = 3
) (
   input  logic                     slower_clk_i,
   input  logic                     arst_i,
   input  logic                     rst_req_i,
   input  logic [NumFifos-1:0]      fifo_wr_reset_is_busy_i,
   input  logic [NumFifos-1:0]      fifo_rd_reset_is_busy_i,
   output logic                     fifo_rst_o,
   output logic                     fifo_rst_done_o,
   output logic [NumFifos-1:0]      busy_status_o,
   output logic                     seeerr_sig_o,
   output logic                     timeout_err_o,
`ifdef DP_FIFOS_RST_SEQ_COUNT_EN
   output logic [15:0]              rst_count_o,
`endif
   output logic [StateBitWidth-1:0] actual_state_o,
   input  logic [StateBitWidth-1:0] actual_state_i
);

   localparam int CW = int'(cnt_width(RstHoldCycles, BusyTimeout));
   localparam logic [CW-1:0] HOLD_LAST = CW'(RstHoldCycles - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(BusyTimeout - 1);

   localparam logic [StateBitWidth-1:0] S_HOLD = StateBitWidth'(ST_RST_HOLD);
   localparam logic [StateBitWidth-1:0] S_WAIT = StateBitWidth'(ST_WAIT_BUSY_OFF);
   localparam logic [StateBitWidth-1:0] S_DONE = StateBitWidth'(ST_DONE);
   localparam logic [StateBitWidth-1:0] S_ERR  = StateBitWidth'(ST_ERROR);

   logic [StateBitWidth-1:0] r_state;
   logic [StateBitWidth-1:0] w_next;
   logic [CW-1:0]            r_cnt;
   logic [CW-1:0]            w_cnt_next;
   logic                     r_timeout;
   logic                     w_set_to;
   logic                     w_any_busy;

   dp_fifos_busy_reduce #(
      .NumFifos(NumFifos)
   ) u_busy (
      .clk_i        (slower_clk_i),
      .arst_i       (arst_i),
      .wr_busy_i    (fifo_wr_reset_is_busy_i),
      .rd_busy_i    (fifo_rd_reset_is_busy_i),
      .busy_status_o(busy_status_o),
      .any_busy_o   (w_any_busy)
   );

   // Next state decodes from the voted state, never from the raw register.
   always_comb begin
      w_next     = actual_state_i;
      w_cnt_next = r_cnt;
      w_set_to   = 1'b0;
      case (actual_state_i)
         S_HOLD: begin
            if (rst_req_i)               w_cnt_next = '0;
            else if (r_cnt == HOLD_LAST) w_next = S_WAIT;
            else                         w_cnt_next = r_cnt + 1'b1;
         end
         S_WAIT: begin
            if (rst_req_i)             w_next = S_HOLD;
            else if (!w_any_busy)      w_next = S_DONE;
            else if (r_cnt == TO_LAST) begin
               w_next   = S_ERR;
               w_set_to = 1'b1;
            end
            else                       w_cnt_next = r_cnt + 1'b1;
         end
         S_DONE: begin
            if (rst_req_i) w_next = S_HOLD;
         end
         S_ERR:   w_next = S_HOLD;
         default: w_next = S_ERR;
      endcase
      if (w_next != actual_state_i) w_cnt_next = '0;
   end

   always_ff @(posedge slower_clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state   <= S_HOLD;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_next;
         r_timeout <= r_timeout | w_set_to;
      end
   end

   assign actual_state_o  = r_state;
   assign timeout_err_o   = r_timeout;
   assign fifo_rst_o      = (actual_state_i == S_HOLD);
   assign fifo_rst_done_o = (actual_state_i == S_DONE);
   assign seeerr_sig_o    = !is_legal_state(32'(actual_state_i));

`ifdef DP_FIFOS_RST_SEQ_COUNT_EN
   logic [15:0] r_rst_count;

   always_ff @(posedge slower_clk_i or posedge arst_i) begin
      if (arst_i)
         r_rst_count <= '0;
      else if (w_next == S_DONE && actual_state_i != S_DONE &&
               r_rst_count != 16'hFFFF)
         r_rst_count <= r_rst_count + 16'd1;
   end

   assign rst_count_o = r_rst_count;
`endif

`ifndef SYNTHESIS
   int   r_hi_cnt;
   int   r_wait_cnt;
   logic r_rst_q;

   always_ff @(posedge slower_clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_hi_cnt   <= 0;
         r_wait_cnt <= 0;
         r_rst_q    <= 1'b1;
      end else begin
         r_rst_q <= fifo_rst_o;
         if (fifo_rst_o) begin
            r_hi_cnt <= r_hi_cnt + 1;
         end else begin
            if (r_hi_cnt != 0)
               assert (r_hi_cnt >= RstHoldCycles)
                  else $error("fifo_rst_o short pulse: %0d", r_hi_cnt);
            r_hi_cnt <= 0;
         end
         // A reset release must resolve to DONE or ERROR in bounded time.
         if (fifo_rst_done_o || fifo_rst_o || seeerr_sig_o ||
             actual_state_i == S_ERR)
            r_wait_cnt <= 0;
         else if (r_rst_q)
            r_wait_cnt <= 1;
         else if (r_wait_cnt != 0)
            r_wait_cnt <= r_wait_cnt + 1;
         assert (r_wait_cnt <= BusyTimeout + 1)
            else $error("rst release never resolved");
      end
   end
`endif

endmodule

// File: tb/tb_dp_fifos_reset_seq.sv
// Directed bench for dp_fifos_reset_seq with looped-back TMR state.
module tb_dp_fifos_reset_seq;

   logic       clk = 1'b0;
   logic       arst;
   logic       rst_req;
   logic [3:0] wr_busy;
   logic [3:0] rd_busy;
   logic       rst_o;
   logic       done_o;
   logic [3:0] busy_st;
   logic       seeerr;
   logic       to_err;
   logic [2:0] st_o;
   logic [2:0] st_i;
   logic       force_bad;
`ifdef DP_FIFOS_RST_SEQ_COUNT_EN
   logic [15:0] rcnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   assign st_i = force_bad ? 3'd6 : st_o;

   always #5 clk = ~clk;

   dp_fifos_reset_seq dut (
      .slower_clk_i           (clk),
      .arst_i                 (arst),
      .rst_req_i              (rst_req),
      .fifo_wr_reset_is_busy_i(wr_busy),
      .fifo_rd_reset_is_busy_i(rd_busy),
      .fifo_rst_o             (rst_o),
      .fifo_rst_done_o        (done_o),
      .busy_status_o          (busy_st),
      .seeerr_sig_o           (seeerr),
      .timeout_err_o          (to_err),
`ifdef DP_FIFOS_RST_SEQ_COUNT_EN
      .rst_count_o            (rcnt),
`endif
      .actual_state_o         (st_o),
      .actual_state_i         (st_i)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b1;
      step();
      step();
      arst = 1'b0;
   endtask

   initial begin
      arst      = 1'b1;
      rst_req   = 1'b0;
      wr_busy   = '0;
      rd_busy   = '0;
      force_bad = 1'b0;

      repeat (5) step();
      chk("rst_in_reset", 32'(rst_o), 1);
      chk("done_in_reset", 32'(done_o), 0);
      chk("seeerr_in_reset", 32'(seeerr), 0);
      chk("to_in_reset", 32'(to_err), 0);
      chk("busy_in_reset", 32'(busy_st), 0);
      arst = 1'b0;

      for (int k = 1; k <= 4; k++) begin
         step();
         chk("boot_rst", 32'(rst_o), (k < 3) ? 1 : 0);
         chk("boot_done", 32'(done_o), (k >= 4) ? 1 : 0);
      end
      repeat (3) begin
         step();
         chk("done_hold", 32'(done_o), 1);
      end

      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      chk("req1_done", 32'(done_o), 0);
      chk("req1_rst", 32'(rst_o), 1);
      step(); chk("req1_rst2", 32'(rst_o), 1);
      step(); chk("req1_rst3", 32'(rst_o), 1);
      step(); chk("req1_rel", 32'(rst_o), 0);
      chk("req1_wait", 32'(done_o), 0);
      step(); chk("req1_done_back", 32'(done_o), 1);

      rst_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("req4_rst", 32'(rst_o), 1);
      end
      rst_req = 1'b0;
      step(); chk("req4_tail1", 32'(rst_o), 1);
      step(); chk("req4_tail2", 32'(rst_o), 1);
      step(); chk("req4_rel", 32'(rst_o), 0);
      step(); chk("req4_done", 32'(done_o), 1);

      force_bad = 1'b1;
      #1;
      chk("bad_seeerr", 32'(seeerr), 1);
      chk("bad_rst", 32'(rst_o), 0);
      chk("bad_done", 32'(done_o), 0);
      step();
      force_bad = 1'b0;
      #1;
      chk("err_state", 32'(st_o), 3);
      chk("err_seeerr", 32'(seeerr), 0);
      chk("err_rst", 32'(rst_o), 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("bad_rec_rst", 32'(rst_o), (k <= 3) ? 1 : 0);
      end
      step();
      chk("bad_rec_done", 32'(done_o), 1);
      chk("bad_no_to", 32'(to_err), 0);

      wr_busy = 4'b0100;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("busy2_status", 32'(busy_st), 32'h4);
         chk("busy2_done", 32'(done_o), 0);
      end
      wr_busy = '0;
      step();
      chk("busy2_clear", 32'(busy_st), 0);
      chk("busy2_not_yet", 32'(done_o), 0);
      step();
      chk("busy2_done_rise", 32'(done_o), 1);

      rd_busy = 4'b0001;
      do_reset();
      repeat (258) step();
      chk("to_wait_rst", 32'(rst_o), 0);
      chk("to_wait_done", 32'(done_o), 0);
      chk("to_not_yet", 32'(to_err), 0);
      step();
      chk("to_set", 32'(to_err), 1);
      chk("to_err_state", 32'(st_o), 3);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("to_retry_rst", 32'(rst_o), (k <= 3) ? 1 : 0);
      end
      rd_busy = '0;
      step();
      chk("to_wait2", 32'(done_o), 0);
      step();
      chk("to_done2", 32'(done_o), 1);
      chk("to_sticky", 32'(to_err), 1);

      do_reset();
      chk("to_cleared", 32'(to_err), 0);

`ifdef DP_FIFOS_RST_SEQ_COUNT_EN
      repeat (4) step();
      chk("cnt_boot_done", 32'(done_o), 1);
      for (int n = 0; n < 3; n++) begin
         rst_req = 1'b1;
         step();
         rst_req = 1'b0;
         repeat (4) step();
         chk("cnt_seq_done", 32'(done_o), 1);
      end
      chk("cnt_four", 32'(rcnt), 4);
      arst = 1'b1;
      #1;
      chk("cnt_cleared", 32'(rcnt), 0);
      step();
      arst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
